// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: flag codes, FSM encoding,
// datapath width and the default acknowledge timeout.
package mem_access_stage_pkg;

  localparam int DATA_W = 32;
  localparam int unsigned ACK_TIMEOUT_DFLT = 16;

  typedef enum logic [2:0] {
    NOT_ACTIVED = 3'b000,
    EQUAL       = 3'b001,
    EXCEPTION   = 3'b010,
    OVERFLOW    = 3'b011,
    UNDERFLOW   = 3'b100,
    ABOVE       = 3'b101
  } flag_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge port; the stage is the master, the memory
// the slave. Request fields stay stable until ack.
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;

  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_timeout_counter.sv
// Counts consecutive cycles with run high; expired flags the LIMIT-th such
// cycle. Built only when MEM_TIMEOUT_EN is defined.
module mem_timeout_counter #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_p0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_p0 <= '0;
    end else if (run) begin
      cnt_p0 <= cnt_p0 + 1'b1;
    end else begin
      cnt_p0 <= '0;
    end
  end

  // cnt_p0 holds the number of completed wait cycles, so LIMIT-1 marks the last one
  assign expired = run && (cnt_p0 == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: registers ALU results, performs word loads/stores over the
// dmem port and emits one write-back beat per instruction. MEM_TIMEOUT_EN
// adds an acknowledge timeout that reports an exception.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DFLT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [2:0]        ex_flag,
  input  logic              ex_branch,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              flush,
  mem_access_stage_if.master dmem,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic [2:0]        wb_flag,
  output logic              wb_branch
);

  state_e state_q, state_d;

  logic accept;
  logic mem_op;
  logic misaligned;
  logic timeout;
  logic ex_ready_c;
  logic dmem_req_c;

  logic              req_we_p0;
  logic [DATA_W-1:0] req_addr_p0;
  logic [DATA_W-1:0] req_wdata_p0;
  logic [4:0]        pend_rd_p0;
  logic              pend_reg_write_p0;
  logic [2:0]        pend_flag_p0;
  logic              pend_branch_p0;

  logic              vld_p1;
  logic [DATA_W-1:0] wb_data_p1;
  logic [4:0]        wb_rd_p1;
  logic              wb_reg_write_p1;
  logic [2:0]        wb_flag_p1;
  logic              wb_branch_p1;

  assign mem_op     = ex_mem_read | ex_mem_write;
  assign misaligned = |ex_result[1:0];
  assign accept     = ex_valid & ex_ready_c & ~flush;

`ifdef MEM_TIMEOUT_EN
  mem_timeout_counter #(.LIMIT(ACK_TIMEOUT)) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .run     (state_q == ACCESS),
    .expired (timeout)
  );
`else
  // Feature compiled out: the access waits for ack indefinitely
  assign timeout = 1'b0 & (ACK_TIMEOUT != 0);
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && mem_op && !misaligned) state_d = ACCESS;
      ACCESS:  if (dmem.ack || timeout)             state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ex_ready_c = 1'b0;
    dmem_req_c = 1'b0;
    case (state_q)
      IDLE:    ex_ready_c = 1'b1;
      ACCESS:  dmem_req_c = 1'b1;
      default: ex_ready_c = 1'b0;
    endcase
  end

  // ---- p0: request capture; a read+write op is issued as a read ----
  always_ff @(posedge clock) begin
    if (!reset) begin
      req_we_p0    <= 1'b0;
      req_addr_p0  <= '0;
      req_wdata_p0 <= '0;
    end else if (accept && mem_op && !misaligned) begin
      req_we_p0    <= ex_mem_write & ~ex_mem_read;
      req_addr_p0  <= ex_result;
      req_wdata_p0 <= ex_store_data;
    end
  end

  always_ff @(posedge clock) begin
    if (accept && mem_op) begin
      pend_rd_p0        <= ex_rd;
      pend_reg_write_p0 <= ex_reg_write;
      pend_flag_p0      <= ex_flag;
      pend_branch_p0    <= ex_branch;
    end
  end

  // ---- p1: write-back beat ----
  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_p1          <= 1'b0;
      wb_data_p1      <= '0;
      wb_rd_p1        <= '0;
      wb_reg_write_p1 <= 1'b0;
      wb_flag_p1      <= '0;
      wb_branch_p1    <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (accept && (!mem_op || misaligned)) begin
        vld_p1          <= 1'b1;
        wb_data_p1      <= ex_result;
        wb_rd_p1        <= ex_rd;
        wb_branch_p1    <= ex_branch;
        wb_reg_write_p1 <= mem_op ? 1'b0 : ex_reg_write;
        wb_flag_p1      <= mem_op ? EXCEPTION : ex_flag;
      end else if ((state_q == ACCESS) && (dmem.ack || timeout)) begin
        vld_p1       <= 1'b1;
        wb_rd_p1     <= pend_rd_p0;
        wb_branch_p1 <= pend_branch_p0;
        // ack in the expiry cycle still completes normally
        if (dmem.ack) begin
          wb_data_p1      <= req_we_p0 ? req_addr_p0 : dmem.rdata;
          wb_reg_write_p1 <= req_we_p0 ? 1'b0 : pend_reg_write_p0;
          wb_flag_p1      <= pend_flag_p0;
        end else begin
          wb_data_p1      <= req_addr_p0;
          wb_reg_write_p1 <= 1'b0;
          wb_flag_p1      <= EXCEPTION;
        end
      end
    end
  end

  assign ex_ready     = ex_ready_c;
  assign dmem.req     = dmem_req_c;
  assign dmem.we      = req_we_p0;
  assign dmem.addr    = req_addr_p0;
  assign dmem.wdata   = req_wdata_p0;
  assign wb_valid     = vld_p1;
  assign wb_data      = wb_data_p1;
  assign wb_rd        = wb_rd_p1;
  assign wb_reg_write = wb_reg_write_p1;
  assign wb_flag      = wb_flag_p1;
  assign wb_branch    = wb_branch_p1;

endmodule
